// File: rtl/sobel_column_feeder_if.sv
// Pixel-in / column-out bundle between the raster source, the column feeder and the Sobel-X stage.
interface sobel_column_feeder_if #(
    parameter int SIZE  = 3,
    parameter int WIDTH = 640
);
    localparam int XW = $clog2(WIDTH);

    logic [7:0]    pix_in;
    logic          pix_valid;
    logic          sof;
    logic [7:0]    col_out [SIZE-1:0];
    logic          col_valid;
    logic [XW-1:0] col_x;
    logic          col_first;
    logic          col_last;

    modport master (
        output pix_in, pix_valid, sof,
        input  col_out, col_valid, col_x, col_first, col_last
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output col_out, col_valid, col_x, col_first, col_last
    );
endinterface

// File: rtl/sobel_column_feeder.sv
// Raster-to-column front end: SIZE-1 line buffers turn a pixel stream into SIZE-tall columns.
// Optional macro FEEDER_BORDER_REPLICATE_EN emits columns from line 0 by replicating the oldest row.
module sobel_column_feeder #(
    parameter int SIZE  = 3,
    parameter int WIDTH = 640
) (
    input logic                 clk,
    input logic                 rst,
    sobel_column_feeder_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(SIZE);

    // y_fill stops counting once SIZE lines of the frame exist
    function automatic logic [YW-1:0] sat_inc(input logic [YW-1:0] v);
        return (v == YW'(SIZE-1)) ? v : v + 1'b1;
    endfunction

`ifdef FEEDER_BORDER_REPLICATE_EN
    function automatic int min_age(input int a, input int y);
        return (a < y) ? a : y;
    endfunction
`endif

    logic [XW-1:0] x_q, x_d, x_eff;
    logic [YW-1:0] yfill_q, yfill_d, yfill_eff;
    logic [7:0]    lb_q [SIZE-1][WIDTH];
    logic [7:0]    rd   [SIZE-1];
    logic          accept;
    logic          at_last;

    logic [7:0]    col_q [SIZE-1:0];
    logic [7:0]    col_d [SIZE-1:0];
    logic          col_valid_q, col_valid_d;
    logic [XW-1:0] col_x_q, col_x_d;
    logic          col_first_q, col_first_d;
    logic          col_last_q, col_last_d;

    assign accept    = bus.pix_valid;
    // sof re-positions the current pixel to the frame origin before anything is read
    assign x_eff     = bus.sof ? '0 : x_q;
    assign yfill_eff = bus.sof ? '0 : yfill_q;
    assign at_last   = (x_eff == XW'(WIDTH-1));

    always_comb begin
        for (int j = 0; j < SIZE-1; j++) begin
            rd[j] = lb_q[j][x_eff];
        end
    end

    always_comb begin
        x_d         = x_q;
        yfill_d     = yfill_q;
        col_d       = col_q;
        col_valid_d = 1'b0;
        col_x_d     = col_x_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        if (accept) begin
            x_d         = at_last ? '0 : x_eff + 1'b1;
            yfill_d     = at_last ? sat_inc(yfill_eff) : yfill_eff;
            col_x_d     = x_eff;
            col_first_d = (x_eff == '0);
            col_last_d  = at_last;
            col_d[SIZE-1] = bus.pix_in;
`ifdef FEEDER_BORDER_REPLICATE_EN
            col_valid_d = 1'b1;
            for (int k = 0; k < SIZE-1; k++) begin
                col_d[k] = bus.pix_in;
                for (int j = 0; j < SIZE-1; j++) begin
                    if (min_age(SIZE-1-k, int'(yfill_eff)) == j+1) begin
                        col_d[k] = rd[j];
                    end
                end
            end
`else
            col_valid_d = (yfill_eff == YW'(SIZE-1));
            for (int k = 0; k < SIZE-1; k++) begin
                col_d[k] = rd[SIZE-2-k];
            end
`endif
        end
    end

    // stage boundary: control state and registered column outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            yfill_q     <= '0;
            col_valid_q <= 1'b0;
            col_x_q     <= '0;
            col_first_q <= 1'b0;
            col_last_q  <= 1'b0;
            for (int k = 0; k < SIZE; k++) begin
                col_q[k] <= '0;
            end
        end else begin
            x_q         <= x_d;
            yfill_q     <= yfill_d;
            col_valid_q <= col_valid_d;
            col_x_q     <= col_x_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            col_q       <= col_d;
        end
    end

    // line buffers shift one age deeper at the accepted column; contents are never cleared
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            lb_q[0][x_eff] <= bus.pix_in;
            for (int j = 1; j < SIZE-1; j++) begin
                lb_q[j][x_eff] <= lb_q[j-1][x_eff];
            end
        end
    end

    assign bus.col_out   = col_q;
    assign bus.col_valid = col_valid_q;
    assign bus.col_x     = col_x_q;
    assign bus.col_first = col_first_q;
    assign bus.col_last  = col_last_q;
endmodule

// File: tb/tb_sobel_column_feeder.sv
// Randomised and directed checks of sobel_column_feeder against a frame-image reference model.
module tb_sobel_column_feeder;
    localparam int SIZE  = 3;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_column_feeder_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    sobel_column_feeder #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_cols   = 0;

    // reference: the current frame as an image, last four lines kept
    logic [7:0] img [4][WIDTH];
    int         m_line = 0;
    int         m_x    = 0;
    logic       e_valid, e_first, e_last;
    int         e_x;
    logic [7:0] e_col [SIZE];
    bit         col_known;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] colp();
        return {bus.col_out[0], bus.col_out[1], bus.col_out[2]};
    endfunction

    task automatic step(input bit r, input bit pv, input bit s, input logic [7:0] p);
        @(negedge clk);
        rst = r; bus.pix_valid = pv; bus.sof = s; bus.pix_in = p;
        @(posedge clk);
        if (r) begin
            m_line = 0; m_x = 0;
            e_valid = 0; e_x = 0; e_first = 0; e_last = 0;
            for (int k = 0; k < SIZE; k++) e_col[k] = 8'd0;
            col_known = 1;
        end else if (pv) begin
            if (s) begin m_line = 0; m_x = 0; end
            img[m_line % 4][m_x] = p;
            e_valid = (m_line >= SIZE-1);
            e_x = m_x; e_first = (m_x == 0); e_last = (m_x == WIDTH-1);
            if (e_valid) begin
                for (int k = 0; k < SIZE; k++) e_col[k] = img[(m_line - (SIZE-1-k)) % 4][m_x];
            end
            col_known = e_valid;
            if (m_x == WIDTH-1) begin m_x = 0; m_line++; end
            else m_x++;
        end else begin
            e_valid = 0;
        end
        #1;
        if (bus.col_valid) n_cols++;
        check("col_valid", 32'(bus.col_valid), 32'(e_valid));
        check("col_x", 32'(bus.col_x), 32'(e_x));
        check("col_first", 32'(bus.col_first), 32'(e_first));
        check("col_last", 32'(bus.col_last), 32'(e_last));
        if (col_known) begin
            for (int k = 0; k < SIZE; k++) check("col_out", 32'(bus.col_out[k]), 32'(e_col[k]));
        end
    endtask

    initial begin
        bus.pix_in = '0; bus.pix_valid = 1'b0; bus.sof = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_col", 32'(colp()), 32'h0);

        // frame 1..12 with a 3-cycle gap between pixels 10 and 11
        n_cols = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, i == 1, 8'(i));
            if (i == 8)  check("p8_valid", 32'(bus.col_valid), 32'h0);
            if (i == 9)  begin
                check("p9_col", 32'(colp()), 32'h010509);
                check("p9_first", 32'(bus.col_first), 32'h1);
            end
            if (i == 10) for (int g = 0; g < 3; g++) step(0, 0, 0, 8'hAA);
            if (i == 12) begin
                check("p12_col", 32'(colp()), 32'h04080C);
                check("p12_last", 32'(bus.col_last), 32'h1);
            end
        end
        check("gap_ncols", 32'(n_cols), 32'd4);
        for (int i = 13; i <= 16; i++) begin
            step(0, 1, 0, 8'(i));
            if (i == 13) check("p13_col", 32'(colp()), 32'h05090D);
        end

        // reset mid-frame, then resend without sof
        for (int i = 1; i <= 9; i++) step(0, 1, i == 1, 8'(i + 40));
        step(1, 1, 0, 8'd50);
        n_cols = 0;
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 0, 8'(i));
            if (i == 8) check("rst_ncols", 32'(n_cols), 32'd0);
            if (i == 9) check("rst_p9", 32'(colp()), 32'h010509);
        end

        // sof mid-line: pixel 6 restarts the frame
        n_cols = 0;
        for (int i = 1; i <= 14; i++) begin
            step(0, 1, (i == 1) || (i == 6), 8'(i + 100));
            if (i == 13) check("sof_ncols", 32'(n_cols), 32'd0);
            if (i == 14) check("sof_first", 32'(bus.col_valid), 32'h1);
        end

        // random traffic with occasional sof and reset
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 59) == 0, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
